// File: rtl/accum_driver.sv
// Initiator for the accumulator's en/done four-phase handshake. It takes addend
// vectors from a valid/ready stream and returns the captured sums on a valid/ready result port.
module accum_driver #(
    parameter int ACCUM_WIDTH = 32,
    parameter int ADD_WIDTH   = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADD_WIDTH-1:0]   in_data [4],
    output logic                   en,
    output logic [ADD_WIDTH-1:0]   add [4],
    input  logic [ACCUM_WIDTH-1:0] accum [4],
    input  logic                   done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACCUM_WIDTH-1:0] res_data [4],
    output logic [15:0]            txn_count,
    output logic                   timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK   = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [15:0]            cnt_reg, cnt_next;
    logic                   en_reg, en_next;
    logic                   res_valid_reg, res_valid_next;
    logic [15:0]            txn_count_reg, txn_count_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [ADD_WIDTH-1:0]   add_reg [4];
    logic [ACCUM_WIDTH-1:0] res_data_reg [4];
    logic                   load, capture, timed_out;

    // A pending done blocks acceptance, so a stale acknowledge can never complete a new request.
    assign in_ready  = reset_l && (state_reg == IDLE) && !done;
    assign timed_out = (cnt_reg == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) state_next = REQ;
            end
            REQ: begin
                if (done)           state_next = ACK;
                else if (timed_out) state_next = DRAIN;
            end
            ACK: begin
                if (!done)          state_next = RESP;
                else if (timed_out) state_next = DRAIN;
            end
            RESP: begin
                if (res_ready) state_next = IDLE;
            end
            DRAIN: begin
                if (!done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        en_next          = en_reg;
        res_valid_next   = res_valid_reg;
        cnt_next         = cnt_reg;
        txn_count_next   = txn_count_reg;
        timeout_err_next = timeout_err_reg;
        load             = 1'b0;
        capture          = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    en_next = 1'b1;
                end
            end
            REQ: begin
                if (done) begin
                    capture  = 1'b1;
                    en_next  = 1'b0;
                    cnt_next = '0;
                end else if (timed_out) begin
                    timeout_err_next = 1'b1;
                    en_next          = 1'b0;
                    cnt_next         = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ACK: begin
                if (!done) begin
                    res_valid_next = 1'b1;
                    cnt_next       = '0;
                end else if (timed_out) begin
                    timeout_err_next = 1'b1;
                    cnt_next         = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    txn_count_next = txn_count_reg + 16'd1;
                end
            end
            DRAIN: begin
                en_next  = 1'b0;
                cnt_next = '0;
            end
            default: begin
                en_next        = 1'b0;
                res_valid_next = 1'b0;
                cnt_next       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_reg         <= '0;
            en_reg          <= 1'b0;
            res_valid_reg   <= 1'b0;
            txn_count_reg   <= '0;
            timeout_err_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                add_reg[i]      <= '0;
                res_data_reg[i] <= '0;
            end
        end else begin
            cnt_reg         <= cnt_next;
            en_reg          <= en_next;
            res_valid_reg   <= res_valid_next;
            txn_count_reg   <= txn_count_next;
            timeout_err_reg <= timeout_err_next;
            // Data lanes pass straight through; the accumulator owns any extension.
            for (int i = 0; i < 4; i++) begin
                if (load)    add_reg[i]      <= in_data[i];
                if (capture) res_data_reg[i] <= accum[i];
            end
        end
    end

    assign en          = en_reg;
    assign res_valid   = res_valid_reg;
    assign txn_count   = txn_count_reg;
    assign timeout_err = timeout_err_reg;
    assign add         = add_reg;
    assign res_data    = res_data_reg;

endmodule

// File: tb/tb_accum_driver.sv
// Bench for accum_driver: a behavioural accumulator on the far side of the handshake,
// a table of directed vectors, hand-written corner sequences and random traffic vs. a sum model.
module tb_accum_driver;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data [4];
    logic        en;
    logic [15:0] add [4];
    logic [31:0] accum [4] = '{default: 32'd0};
    logic        done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data [4];
    logic [15:0] txn_count;
    logic        timeout_err;

    logic        acc_mute = 1'b0;
    logic        acc_clear = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] exp_acc [4] = '{default: 32'd0};

    typedef struct {
        bit               clr;
        logic [3:0][15:0] d;
        int               hold;
        logic [3:0][31:0] exp;
    } vec_t;
    vec_t tbl [$];

    accum_driver #(.ACCUM_WIDTH(32), .ADD_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .en(en), .add(add), .accum(accum), .done(done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .txn_count(txn_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Accumulator: registers done one edge after seeing en, drops it one edge after en falls.
    always @(posedge clk) begin
        if (acc_clear) begin
            for (int i = 0; i < 4; i++) accum[i] <= 32'd0;
            done <= 1'b0;
        end else if (en && !done && !acc_mute) begin
            for (int i = 0; i < 4; i++) accum[i] <= accum[i] + {16'd0, add[i]};
            done <= 1'b1;
        end else if (!en && done) begin
            done <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        for (int i = 0; i < 4; i++) exp_acc[i] = 32'd0;
    endtask

    task automatic add_vec(input bit clr, input logic [15:0] d0, d1, d2, d3, input int hold,
                           input logic [31:0] e0, e1, e2, e3);
        vec_t v;
        v.clr = clr;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.hold = hold;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        tbl.push_back(v);
    endtask

    // One full transaction with timing checks; hold = cycles res_ready stays low after res_valid rises.
    task automatic run_txn(input logic [3:0][15:0] d, input int hold, output logic [3:0][31:0] r);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) in_data[i] = d[i];
        in_valid  = 1'b1;
        res_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) check("add_lane", add[i], d[i]);
        lat = 0;
        while (!res_valid && lat < 40) begin
            check("in_ready_busy", in_ready, 0);
            check("en_phase", en, (lat < 2) ? 1 : 0);
            tick();
            lat++;
        end
        check("res_latency", lat, 4);
        for (int i = 0; i < 4; i++) r[i] = res_data[i];
        for (int k = 0; k < hold; k++) begin
            tick();
            check("bp_res_valid", res_valid, 1);
            for (int i = 0; i < 4; i++) check("bp_res_data", res_data[i], r[i]);
            check("bp_in_ready", in_ready, 0);
            check("bp_txn_count", txn_count, exp_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check("res_valid_fall", res_valid, 0);
        check("txn_count", txn_count, exp_cnt);
        check("in_ready_after", in_ready, 1);
        $display("txn %0d: in={%0h,%0h,%0h,%0h} res={%0h,%0h,%0h,%0h} hold=%0d count=%0d",
                 exp_cnt, d[0], d[1], d[2], d[3], r[0], r[1], r[2], r[3], hold, txn_count);
    endtask

    initial begin
        logic [3:0][31:0] r;
        logic [3:0][15:0] d;
        int hold;

        for (int i = 0; i < 4; i++) in_data[i] = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_txn_count", txn_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_add", add[i], 0);
            check("rst_res_data", res_data[i], 0);
        end
        @(negedge clk);
        reset_l = 1'b1;
        tick();

        // Directed table: single txn, back-to-back accumulation, backpressure
        add_vec(1, 16'd1, 16'd2, 16'd3, 16'd4, 0, 32'd1, 32'd2, 32'd3, 32'd4);
        add_vec(1, 16'hFFFF, 16'd1, 16'd0, 16'h8000, 0, 32'hFFFF, 32'd1, 32'd0, 32'h8000);
        add_vec(0, 16'hFFFF, 16'd1, 16'd0, 16'h8000, 0, 32'h1FFFE, 32'd2, 32'd0, 32'h10000);
        add_vec(0, 16'd0, 16'd0, 16'd0, 16'd0, 10, 32'h1FFFE, 32'd2, 32'd0, 32'h10000);
        add_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 32'h2FFFD, 32'h10001, 32'hFFFF, 32'h1FFFF);
        foreach (tbl[t]) begin
            if (tbl[t].clr) clear_acc();
            run_txn(tbl[t].d, tbl[t].hold, r);
            for (int i = 0; i < 4; i++) begin
                check("tbl_res", r[i], tbl[t].exp[i]);
                exp_acc[i] = tbl[t].exp[i];
            end
        end

        // Timeout: accumulator never answers
        acc_mute = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i] = 16'(i + 5);
        in_valid  = 1'b1;
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            check("to_en_held", en, 1);
            check("to_err_clear", timeout_err, 0);
        end
        tick();
        check("to_en_drop", en, 0);
        check("to_err_set", timeout_err, 1);
        check("to_no_res", res_valid, 0);
        tick();
        check("to_idle", in_ready, 1);
        check("to_no_res2", res_valid, 0);
        check("to_txn_count", txn_count, exp_cnt);
        res_ready = 1'b0;
        acc_mute  = 1'b0;
        d = {16'd40, 16'd30, 16'd20, 16'd10};
        run_txn(d, 0, r);
        for (int i = 0; i < 4; i++) begin
            exp_acc[i] = exp_acc[i] + {16'd0, d[i]};
            check("to_after_res", r[i], exp_acc[i]);
        end
        check("to_err_sticky", timeout_err, 1);

        // Random traffic against the sum model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
            hold = $urandom_range(0, 3);
            run_txn(d, hold, r);
            for (int i = 0; i < 4; i++) begin
                exp_acc[i] = exp_acc[i] + {16'd0, d[i]};
                check("rand_res", r[i], exp_acc[i]);
            end
        end
        check("rand_err_sticky", timeout_err, 1);

        // Reset while in ACK
        for (int i = 0; i < 4; i++) in_data[i] = 16'd9;
        in_valid  = 1'b1;
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_in_ack", en, 0);
        reset_l = 1'b0;
        #1;
        check("mid_rst_en", en, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_txn_count", txn_count, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        check("mid_rst_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_add", add[i], 0);
            check("mid_rst_res_data", res_data[i], 0);
        end
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        #1;
        clear_acc();
        exp_cnt = 16'd0;
        d = {16'd7, 16'd6, 16'd5, 16'd4};
        run_txn(d, 0, r);
        for (int i = 0; i < 4; i++) check("mid_fresh_res", r[i], {16'd0, d[i]});
        check("mid_fresh_count", txn_count, 1);
        exp_acc[0] = 32'd4; exp_acc[1] = 32'd5; exp_acc[2] = 32'd6; exp_acc[3] = 32'd7;

        // Counter wrap: preload the count one short of wrapping
        force dut.txn_count_reg = 16'hFFFF;
        tick();
        release dut.txn_count_reg;
        tick();
        check("wrap_preload", txn_count, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        d = {16'd1, 16'd1, 16'd1, 16'd1};
        run_txn(d, 1, r);
        check("wrap_zero", txn_count, 0);
        for (int i = 0; i < 4; i++) begin
            exp_acc[i] = exp_acc[i] + {16'd0, d[i]};
            check("wrap_res", r[i], exp_acc[i]);
        end
        check("wrap_err", timeout_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
